// File: rtl/gbe_mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, optional min-length padding (GBE_MAC_TX_PAD_EN), FCS, IFG.
// Consumes bytes from the packet engine via mac_tx_dvld/mac_tx_ack and flags oversize frames.
module gbe_mac_tx_framer #(
  parameter int unsigned IFG_CYCLES      = 12,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned MAX_FRAME_BYTES = 1514
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic [7:0]  mac_tx_data,
  input  logic        mac_tx_dvld,
  output logic        mac_tx_ack,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic [31:0] tx_frame_count,
  output logic [15:0] tx_oversize_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
`ifdef GBE_MAC_TX_PAD_EN
    ST_PAD,
`endif
    ST_FCS,
    ST_IFG
  } state_e;

  state_e      state_q;
  logic [7:0]  txd_q;
  logic        en_q, er_q, busy_q, ovf_q;
  logic [2:0]  pre_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [23:0] fcs_q;
  logic [1:0]  fcs_idx_q;
  logic [31:0] ifg_q;
  logic [31:0] frames_q;
  logic [15:0] ovs_q;
  logic [7:0]  crc_in;

`ifndef GBE_MAC_TX_PAD_EN
  logic [31:0] unused_min;
  assign unused_min = MIN_FRAME_BYTES;
`endif

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Pad bytes feed zeros into the CRC; data bytes only when actually accepted.
  always_comb begin
    crc_in = (state_q == ST_DATA && mac_tx_dvld) ? mac_tx_data : 8'h00;
    crc_d  = crc_byte(crc_q, crc_in);
    cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  assign mac_tx_ack        = (state_q == ST_DATA) && mac_tx_dvld;
  assign gmii_txd          = txd_q;
  assign gmii_tx_en        = en_q;
  assign gmii_tx_er        = er_q;
  assign tx_busy           = busy_q;
  assign tx_frame_count    = frames_q;
  assign tx_oversize_count = ovs_q;

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q   <= ST_IDLE;
      txd_q     <= '0;
      en_q      <= 1'b0;
      er_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      pre_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= '1;
      fcs_q     <= '0;
      fcs_idx_q <= '0;
      ifg_q     <= '0;
      frames_q  <= '0;
      ovs_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mac_tx_dvld) begin
            state_q <= ST_PRE;
            txd_q   <= 8'h55;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            pre_q   <= 3'd1;
          end
        end
        ST_PRE: begin
          txd_q <= 8'h55;
          pre_q <= pre_q + 3'd1;
          if (pre_q == 3'd6) state_q <= ST_SFD;
        end
        ST_SFD: begin
          txd_q   <= 8'hD5;
          cnt_q   <= '0;
          crc_q   <= '1;
          ovf_q   <= 1'b0;
          state_q <= ST_DATA;
        end
        // The frame end is detected on the same edge that emits the next byte,
        // so pad/FCS follow the last data byte without a bubble.
        ST_DATA: begin
          if (mac_tx_dvld) begin
            txd_q <= mac_tx_data;
            cnt_q <= cnt_d;
            crc_q <= crc_d;
            if ({16'h0000, cnt_d} > MAX_FRAME_BYTES) begin
              er_q  <= 1'b1;
              ovf_q <= 1'b1;
            end
          end else begin
`ifdef GBE_MAC_TX_PAD_EN
            if ({16'h0000, cnt_q} < MIN_FRAME_BYTES) begin
              txd_q   <= 8'h00;
              cnt_q   <= cnt_d;
              crc_q   <= crc_d;
              state_q <= ST_PAD;
            end else begin
              txd_q     <= ~crc_q[7:0];
              fcs_q     <= ~crc_q[31:8];
              fcs_idx_q <= 2'd1;
              state_q   <= ST_FCS;
            end
`else
            txd_q     <= ~crc_q[7:0];
            fcs_q     <= ~crc_q[31:8];
            fcs_idx_q <= 2'd1;
            state_q   <= ST_FCS;
`endif
          end
        end
`ifdef GBE_MAC_TX_PAD_EN
        ST_PAD: begin
          if ({16'h0000, cnt_q} >= MIN_FRAME_BYTES) begin
            txd_q     <= ~crc_q[7:0];
            fcs_q     <= ~crc_q[31:8];
            fcs_idx_q <= 2'd1;
            state_q   <= ST_FCS;
          end else begin
            txd_q <= 8'h00;
            cnt_q <= cnt_d;
            crc_q <= crc_d;
          end
        end
`endif
        ST_FCS: begin
          txd_q     <= fcs_q[7:0];
          fcs_q     <= fcs_q >> 8;
          fcs_idx_q <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_q  <= ST_IFG;
            ifg_q    <= '0;
            frames_q <= frames_q + 32'd1;
            if (ovf_q && ovs_q != 16'hFFFF) ovs_q <= ovs_q + 16'd1;
          end
        end
        // Stays in IFG through the last idle cycle so a waiting frame starts with no extra gap.
        ST_IFG: begin
          if (ifg_q == IFG_CYCLES) begin
            if (mac_tx_dvld) begin
              state_q <= ST_PRE;
              txd_q   <= 8'h55;
              en_q    <= 1'b1;
              pre_q   <= 3'd1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            txd_q <= 8'h00;
            en_q  <= 1'b0;
            er_q  <= 1'b0;
            ifg_q <= ifg_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbe_mac_tx_framer.sv
// Randomized bench for gbe_mac_tx_framer; GMII stream checked against a table-driven frame model.
// Honours GBE_MAC_TX_PAD_EN to select padded or natural-length expectations.
module tb_gbe_mac_tx_framer;
  localparam int unsigned MINB = 60;
  localparam int unsigned MAXB = 1514;
  localparam int unsigned IFG  = 12;

  logic        mac_clk = 1'b0;
  logic        mac_rst_n;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_ack;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er, tx_busy;
  logic [31:0] tx_frame_count;
  logic [15:0] tx_oversize_count;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int exp_ovs = 0;

  always #4 mac_clk = ~mac_clk;

  gbe_mac_tx_framer #(
    .IFG_CYCLES(IFG), .MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .mac_clk(mac_clk), .mac_rst_n(mac_rst_n),
    .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .tx_busy(tx_busy), .tx_frame_count(tx_frame_count), .tx_oversize_count(tx_oversize_count)
  );

  // Passive monitor: captured bytes, tx_en run lengths and idle gaps between runs.
  logic [7:0] cap_d[$];
  logic       cap_e[$];
  int         runs[$];
  int         gaps[$];
  int         run_len = 0, gap_len = 0, ack_in_gap = 0;
  logic       prev_en = 1'b0;

  always @(negedge mac_clk) begin
    if (gmii_tx_en === 1'b1) begin
      cap_d.push_back(gmii_txd);
      cap_e.push_back(gmii_tx_er);
      if (!prev_en && runs.size() > 0) gaps.push_back(gap_len);
      run_len++;
    end else begin
      if (prev_en) begin
        runs.push_back(run_len);
        run_len = 0;
        gap_len = 0;
      end
      gap_len++;
      if (tx_busy === 1'b1 && mac_tx_ack === 1'b1) ack_in_gap++;
    end
    prev_en = (gmii_tx_en === 1'b1);
  end

  logic [31:0] crc_tab [256];

  function automatic void init_tab();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endfunction

  function automatic logic [31:0] fcs_of(input logic [7:0] body[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ body[i]];
    return ~c;
  endfunction

  // Expected GMII byte/er sequence for one frame while tx_en is high.
  function automatic void build_expect(input logic [7:0] fr[$], output logic [7:0] ed[$], output logic ee[$]);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    body = fr;
`ifdef GBE_MAC_TX_PAD_EN
    while (body.size() < MINB) body.push_back(8'h00);
`endif
    fcs = fcs_of(body);
    ed.delete();
    ee.delete();
    repeat (7) begin ed.push_back(8'h55); ee.push_back(1'b0); end
    ed.push_back(8'hD5); ee.push_back(1'b0);
    foreach (body[i]) begin ed.push_back(body[i]); ee.push_back(i >= MAXB); end
    for (int k = 0; k < 4; k++) begin
      ed.push_back(fcs[8*k +: 8]);
      ee.push_back(fr.size() > MAXB);
    end
  endfunction

  function automatic int count_mism(input logic [7:0] ed[$], input logic ee[$], input int c0);
    int m;
    m = 0;
    for (int i = 0; i < ed.size(); i++)
      if (c0 + i >= cap_d.size() || cap_d[c0+i] !== ed[i] || cap_e[c0+i] !== ee[i]) m++;
    return m;
  endfunction

  function automatic void rand_frame(input int n, output logic [7:0] fr[$]);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
  endfunction

  // Source model: holds dvld, advances the byte the cycle after each ack.
  // Returns early (dvld still high) when byte index stop_at is being presented.
  task automatic drive_frame(input logic [7:0] fr[$], input int stop_at, output int acks);
    int idx, cyc;
    idx = 0; cyc = 0; acks = 0;
    mac_tx_dvld = 1'b1;
    mac_tx_data = fr[0];
    while (idx < fr.size()) begin
      #1;
      if (idx == stop_at) return;
      if (mac_tx_ack === 1'b1) begin idx++; acks++; end
      @(negedge mac_clk);
      cyc++;
      if (cyc > fr.size() + 200) begin
        checks++; failures++;
        $display("FAIL drive_timeout acked=%0d required=%0d", acks, fr.size());
        break;
      end
      if (idx < fr.size()) mac_tx_data = fr[idx];
    end
    mac_tx_dvld = 1'b0;
    mac_tx_data = 8'h00;
    @(negedge mac_clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy === 1'b1 || gmii_tx_en === 1'b1) begin
      @(negedge mac_clk);
      n++;
      if (n > budget) begin
        checks++; failures++;
        $display("FAIL idle_timeout busy=%b required=0", tx_busy);
        return;
      end
    end
    @(negedge mac_clk);
  endtask

  task automatic test_reset();
    mac_rst_n = 1'b0; mac_tx_dvld = 1'b1; mac_tx_data = 8'hA5;
    repeat (3) @(negedge mac_clk);
    checks++; if (gmii_tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", gmii_tx_en); end
    checks++; if (gmii_tx_er !== 1'b0) begin failures++; $display("FAIL reset_tx_er got=%b exp=0", gmii_tx_er); end
    checks++; if (gmii_txd !== 8'h00) begin failures++; $display("FAIL reset_txd got=%h exp=00", gmii_txd); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (mac_tx_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", mac_tx_ack); end
    checks++; if (tx_frame_count !== 32'd0) begin failures++; $display("FAIL reset_frames got=%0d exp=0", tx_frame_count); end
    checks++; if (tx_oversize_count !== 16'd0) begin failures++; $display("FAIL reset_ovs got=%0d exp=0", tx_oversize_count); end
    mac_tx_dvld = 1'b0; mac_tx_data = 8'h00;
    @(negedge mac_clk);
    mac_rst_n = 1'b1;
    repeat (2) @(negedge mac_clk);
  endtask

  task automatic test_frame64();
    logic [7:0] fr[$], ed[$]; logic ee[$]; int acks, c0, r0, m;
    rand_frame(64, fr);
    build_expect(fr, ed, ee);
    c0 = cap_d.size(); r0 = runs.size();
    drive_frame(fr, -1, acks);
    wait_idle(200);
    exp_frames++;
    m = count_mism(ed, ee, c0);
    checks++; if (acks != 64) begin failures++; $display("FAIL f64_acks got=%0d exp=64", acks); end
    checks++; if (runs.size() != r0 + 1 || runs[r0] != 76) begin failures++; $display("FAIL f64_run got=%0d exp=76", runs[r0]); end
    checks++; if (m != 0) begin failures++; $display("FAIL f64_stream mismatched=%0d exp=0", m); end
    checks++; if (tx_frame_count !== 32'(exp_frames)) begin failures++; $display("FAIL f64_frames got=%0d exp=%0d", tx_frame_count, exp_frames); end
  endtask

  task automatic test_check_value();
    logic [7:0] fr[$], ed[$], want[$]; logic ee[$]; int acks, c0, r0, m, bad;
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    build_expect(fr, ed, ee);
    c0 = cap_d.size(); r0 = runs.size();
    drive_frame(fr, -1, acks);
    wait_idle(200);
    exp_frames++;
    m = count_mism(ed, ee, c0);
    checks++; if (m != 0) begin failures++; $display("FAIL chk_stream mismatched=%0d exp=0", m); end
`ifdef GBE_MAC_TX_PAD_EN
    checks++; if (runs[r0] != 72) begin failures++; $display("FAIL chk_run got=%0d exp=72", runs[r0]); end
`else
    want = {8'h26, 8'h39, 8'hF4, 8'hCB};
    bad = 0;
    for (int i = 0; i < 4; i++) if (cap_d[c0 + 17 + i] !== want[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL chk_fcs got=%h%h%h%h exp=2639f4cb", cap_d[c0+17], cap_d[c0+18], cap_d[c0+19], cap_d[c0+20]); end
    checks++; if (runs[r0] != 21) begin failures++; $display("FAIL chk_run got=%0d exp=21", runs[r0]); end
`endif
  endtask

  task automatic test_short_pad();
    logic [7:0] fr[$], ed[$]; logic ee[$]; int acks, c0, r0, m, exp_run;
    rand_frame(10, fr);
    build_expect(fr, ed, ee);
`ifdef GBE_MAC_TX_PAD_EN
    exp_run = 72;
`else
    exp_run = 22;
`endif
    c0 = cap_d.size(); r0 = runs.size();
    drive_frame(fr, -1, acks);
    wait_idle(200);
    exp_frames++;
    m = count_mism(ed, ee, c0);
    checks++; if (runs[r0] != exp_run) begin failures++; $display("FAIL short_run got=%0d exp=%0d", runs[r0], exp_run); end
    checks++; if (m != 0) begin failures++; $display("FAIL short_stream mismatched=%0d exp=0", m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[$], f2[$], e1[$], e2[$]; logic x1[$], x2[$];
    int a1, a2, c0, r0, g0, m1, m2;
    rand_frame(100, f1); rand_frame(100, f2);
    build_expect(f1, e1, x1); build_expect(f2, e2, x2);
    c0 = cap_d.size(); r0 = runs.size(); g0 = ack_in_gap;
    drive_frame(f1, -1, a1);
    drive_frame(f2, -1, a2);
    wait_idle(300);
    exp_frames += 2;
    m1 = count_mism(e1, x1, c0);
    m2 = count_mism(e2, x2, c0 + e1.size());
    checks++; if (runs.size() != r0 + 2 || runs[r0] != 112 || runs[r0+1] != 112) begin failures++; $display("FAIL b2b_runs got=%0d,%0d exp=112,112", runs[r0], runs[r0+1]); end
    checks++; if (gaps[gaps.size()-1] != IFG) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gaps[gaps.size()-1], IFG); end
    checks++; if (m1 + m2 != 0) begin failures++; $display("FAIL b2b_stream mismatched=%0d exp=0", m1 + m2); end
    checks++; if (ack_in_gap != g0) begin failures++; $display("FAIL b2b_ack_in_ifg got=%0d exp=0", ack_in_gap - g0); end
    checks++; if (a1 + a2 != 200) begin failures++; $display("FAIL b2b_acks got=%0d exp=200", a1 + a2); end
    checks++; if (tx_frame_count !== 32'(exp_frames)) begin failures++; $display("FAIL b2b_frames got=%0d exp=%0d", tx_frame_count, exp_frames); end
  endtask

  task automatic test_oversize();
    logic [7:0] fr[$], ed[$]; logic ee[$]; int acks, c0, m, ers;
    rand_frame(1520, fr);
    build_expect(fr, ed, ee);
    c0 = cap_d.size();
    drive_frame(fr, -1, acks);
    wait_idle(200);
    exp_frames++; exp_ovs++;
    m = count_mism(ed, ee, c0);
    ers = 0;
    for (int i = c0; i < cap_e.size(); i++) if (cap_e[i] === 1'b1) ers++;
    checks++; if (acks != 1520) begin failures++; $display("FAIL ovs_acks got=%0d exp=1520", acks); end
    checks++; if (ers != 10) begin failures++; $display("FAIL ovs_er_bytes got=%0d exp=10", ers); end
    checks++; if (m != 0) begin failures++; $display("FAIL ovs_stream mismatched=%0d exp=0", m); end
    checks++; if (tx_oversize_count !== 16'(exp_ovs)) begin failures++; $display("FAIL ovs_count got=%0d exp=%0d", tx_oversize_count, exp_ovs); end
    checks++; if (tx_frame_count !== 32'(exp_frames)) begin failures++; $display("FAIL ovs_frames got=%0d exp=%0d", tx_frame_count, exp_frames); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] fr[$], ed[$]; logic ee[$]; int acks, c0, r0, m;
    rand_frame(64, fr);
    drive_frame(fr, 29, acks);
    mac_rst_n = 1'b0;
    #1;
    checks++; if (gmii_tx_en !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_en got=%b exp=0", gmii_tx_en); end
    checks++; if (mac_tx_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", mac_tx_ack); end
    mac_tx_dvld = 1'b0; mac_tx_data = 8'h00;
    exp_frames = 0; exp_ovs = 0;
    @(negedge mac_clk);
    @(negedge mac_clk);
    mac_rst_n = 1'b1;
    repeat (2) @(negedge mac_clk);
    checks++; if (tx_frame_count !== 32'd0) begin failures++; $display("FAIL rst_mid_frames got=%0d exp=0", tx_frame_count); end
    rand_frame(64, fr);
    build_expect(fr, ed, ee);
    c0 = cap_d.size(); r0 = runs.size();
    drive_frame(fr, -1, acks);
    wait_idle(200);
    exp_frames++;
    m = count_mism(ed, ee, c0);
    checks++; if (runs[r0] != 76 || m != 0) begin failures++; $display("FAIL rst_after_frame run=%0d mismatched=%0d exp=76,0", runs[r0], m); end
    checks++; if (tx_frame_count !== 32'(exp_frames)) begin failures++; $display("FAIL rst_after_frames got=%0d exp=%0d", tx_frame_count, exp_frames); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    init_tab();
    mac_rst_n = 1'b0; mac_tx_dvld = 1'b0; mac_tx_data = 8'h00;
    @(negedge mac_clk);
    test_reset();
    test_frame64();
    test_check_value();
    test_short_pad();
    test_back_to_back();
    test_oversize();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
